pwm_sample_sched: RTL and testbench

Sample scheduler between a bursty audio sample producer (voice mixer, CPU writes, test generator) and `pwm_audio`. It buffers incoming 8-bit samples in a small FIFO and releases exactly one sample per PWM frame on a fixed frame boundary, so the PWM duty only ever changes between frames. It handles start-up priming, underrun and mute, and drives `pwm_audio.sample` directly.

---
 rtl/pwm_sample_sched_if.sv | 27 ++
 rtl/pwm_sample_sched.sv | 140 ++++++++++++++
 tb/tb_pwm_sample_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_sample_sched_if.sv
// Producer handshake plus the PWM-facing outputs of pwm_sample_sched.
// The master side is the producer or bench; the slave side is the scheduler.
interface pwm_sample_sched_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          enable;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    sample;
  logic          frame_start;
  logic [LW-1:0] level;
  logic          underrun;
  logic [15:0]   underrun_cnt;

  modport master (
    output enable, in_data, in_valid,
    input  in_ready, sample, frame_start, level, underrun, underrun_cnt
  );

  modport slave (
    input  enable, in_data, in_valid,
    output in_ready, sample, frame_start, level, underrun, underrun_cnt
  );
endinterface

// File: rtl/pwm_sample_sched.sv
// Buffers bursty 8-bit samples and releases one per PWM frame on the frame boundary,
// with start-up priming, underrun recovery and mute/flush.
module pwm_sample_sched #(
  parameter int PERIOD   = 255,
  parameter int DEPTH    = 8,
  parameter int MIDSCALE = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_sample_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [FW-1:0] FC_LAST   = FW'(PERIOD - 1);
  localparam logic [FW-1:0] FC_PRE    = FW'(PERIOD - 2);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PRIME = LW'(DEPTH / 2);
  localparam logic [7:0]    MID       = 8'(MIDSCALE);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_e;

  state_e        r_state, w_state_nxt;
  logic [FW-1:0] r_fc;
  logic          r_frame_start;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_sample;
  logic          r_underrun;
  logic [15:0]   r_underrun_cnt;

  logic w_boundary, w_in_ready, w_push, w_pop, w_flush, w_load_mid, w_underrun;

  assign w_boundary = (r_fc == FC_LAST);
  assign w_in_ready = bus.enable && (r_state != S_IDLE) && (r_level < LVL_FULL);
  assign w_push     = bus.in_valid && w_in_ready;

  // frame_start is registered one cycle ahead so it is a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fc          <= '0;
      r_frame_start <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      r_fc          <= w_boundary ? '0 : r_fc + FW'(1);
      r_frame_start <= (r_fc == FC_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_load_mid  = 1'b0;
    w_underrun  = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = S_IDLE;
      w_flush     = 1'b1;
      w_load_mid  = w_boundary;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_PRIME;
          w_flush     = 1'b1;
          w_load_mid  = w_boundary;
        end
        S_PRIME: begin
          if (w_boundary && (r_level >= LVL_PRIME)) begin
            w_pop       = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (w_boundary) begin
            if (r_level != '0) begin
              w_pop = 1'b1;
            end else begin
              w_underrun  = 1'b1;
              w_state_nxt = S_PRIME;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_flush     = 1'b1;
        end
      endcase
    end
  end

  // Pop decisions use the registered level, so a same-edge push is never popped early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone define valid entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample       <= MID;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_pop)           r_sample <= r_mem[r_rd_ptr];
      else if (w_load_mid) r_sample <= MID;
      r_underrun <= w_underrun;
      if (w_underrun && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.sample       = r_sample;
  assign bus.frame_start  = r_frame_start;
  assign bus.level        = r_level;
  assign bus.underrun     = r_underrun;
  assign bus.underrun_cnt = r_underrun_cnt;
endmodule

// File: tb/tb_pwm_sample_sched.sv
// Bench for pwm_sample_sched: directed frame-level vectors, hand sequences for
// backpressure/mute/reset, then random traffic against a queue-based reference model.
module tb_pwm_sample_sched;
  localparam int PERIOD   = 255;
  localparam int DEPTH    = 8;
  localparam int MIDSCALE = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_sample_sched_if #(.DEPTH(DEPTH)) bus ();
  pwm_sample_sched #(.PERIOD(PERIOD), .DEPTH(DEPTH), .MIDSCALE(MIDSCALE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks;
  int n_errors;
  int cyc;
  int fs_log[$];

  // Reference model: a queue of pending samples and the play mode, advanced once per clock.
  typedef enum {M_IDLE, M_PRIME, M_RUN} mode_e;
  mode_e      m_mode;
  logic [7:0] m_q[$];
  int         m_pos;
  logic [7:0] m_sample;
  logic       m_und;
  int         m_cnt;

  typedef struct {
    logic       en;
    int         n_push;
    logic [7:0] base;
    int         n_bound;
    logic [7:0] exp_sample;
    int         exp_level;
    int         exp_cnt;
    logic       exp_und;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode   = M_IDLE;
    m_pos    = 0;
    m_sample = 8'(MIDSCALE);
    m_und    = 1'b0;
    m_cnt    = 0;
    cyc      = 0;
    fs_log.delete();
  endtask

  function automatic logic exp_rdy(input logic en);
    return (m_mode != M_IDLE) && en && (m_q.size() < DEPTH);
  endfunction

  task automatic model_step(input logic en, input logic vld, input logic [7:0] d);
    logic bnd;
    logic rdy;
    bnd   = (m_pos == PERIOD - 1);
    rdy   = exp_rdy(en);
    m_und = 1'b0;
    if (!en || m_mode == M_IDLE) begin
      if (bnd) m_sample = 8'(MIDSCALE);
      m_q.delete();
      m_mode = en ? M_PRIME : M_IDLE;
    end else if (bnd) begin
      if (m_q.size() >= DEPTH / 2 || (m_mode == M_RUN && m_q.size() > 0)) begin
        m_sample = m_q.pop_front();
        m_mode   = M_RUN;
      end else if (m_mode == M_RUN) begin
        m_und = 1'b1;
        if (m_cnt < 65535) m_cnt++;
        m_mode = M_PRIME;
      end
    end
    if (rdy && vld) m_q.push_back(d);
    m_pos = (m_pos + 1) % PERIOD;
  endtask

  task automatic check_outputs();
    check("sample",       bus.sample,       m_sample);
    check("level",        bus.level,        m_q.size());
    check("frame_start",  bus.frame_start,  m_pos == PERIOD - 1);
    check("underrun",     bus.underrun,     m_und);
    check("underrun_cnt", bus.underrun_cnt, m_cnt);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_sample"},       bus.sample,       MIDSCALE);
    check({tag, "_level"},        bus.level,        0);
    check({tag, "_in_ready"},     bus.in_ready,     0);
    check({tag, "_frame_start"},  bus.frame_start,  0);
    check({tag, "_underrun"},     bus.underrun,     0);
    check({tag, "_underrun_cnt"}, bus.underrun_cnt, 0);
  endtask

  // One clock: drive on the falling edge, model and sample just after the rising edge.
  task automatic tick(input logic en, input logic vld, input logic [7:0] d, output logic acc);
    @(negedge clk);
    bus.enable   = en;
    bus.in_valid = vld;
    bus.in_data  = d;
    #1;
    check("in_ready", bus.in_ready, exp_rdy(en));
    acc = bus.in_ready && vld;
    @(posedge clk);
    model_step(en, vld, d);
    cyc++;
    #1;
    check_outputs();
    if (bus.frame_start) fs_log.push_back(cyc);
  endtask

  task automatic push_one(input logic en, input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) tick(en, 1'b1, d, acc);
    check("push_accepted", acc, 1);
  endtask

  task automatic run_bounds(input logic en, input int n);
    logic acc;
    int   seen;
    seen = 0;
    for (int k = 0; k < n * PERIOD + 2 && seen < n; k++) begin
      tick(en, 1'b0, 8'd0, acc);
      if (m_pos == 0) seen++;
    end
    check("bounds_reached", seen, n);
  endtask

  task automatic frame_hold(inout logic [7:0] val, output int acc_cnt,
                            output logic [31:0] lvl_late, output logic rdy_late);
    logic acc;
    acc_cnt  = 0;
    lvl_late = '0;
    rdy_late = 1'b1;
    for (int k = 0; k < PERIOD + 2; k++) begin
      tick(1'b1, 1'b1, val, acc);
      if (acc) begin
        val++;
        acc_cnt++;
      end
      if (m_pos == PERIOD - 1) begin
        lvl_late = bus.level;
        rdy_late = bus.in_ready;
      end
      if (m_pos == 0) break;
    end
  endtask

  initial begin
    logic        acc;
    logic [7:0]  nv;
    int          acc_cnt;
    logic [31:0] lvl_late;
    logic        rdy_late;
    int          fs_exp[3];
    int          exp_acc[3];
    logic [7:0]  exp_smp[3];

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    fs_exp   = '{254, 509, 764};
    exp_acc  = '{5, 1, 1};
    exp_smp  = '{8'd60, 8'd70, 8'd80};

    //          en    push base   bnd sample  lvl cnt und
    vecs[0] = '{1'b0, 0, 8'd0,  3, 8'd128, 0, 0, 1'b0};
    vecs[1] = '{1'b1, 4, 8'd10, 1, 8'd10,  3, 0, 1'b0};
    vecs[2] = '{1'b1, 0, 8'd0,  1, 8'd20,  2, 0, 1'b0};
    vecs[3] = '{1'b1, 0, 8'd0,  1, 8'd30,  1, 0, 1'b0};
    vecs[4] = '{1'b1, 0, 8'd0,  1, 8'd40,  0, 0, 1'b0};
    vecs[5] = '{1'b1, 0, 8'd0,  1, 8'd40,  0, 1, 1'b1};
    vecs[6] = '{1'b1, 4, 8'd50, 1, 8'd50,  3, 1, 1'b0};

    rst_n        = 1'b1;
    bus.enable   = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    bus.enable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Frame-level directed vectors: idle, prime and play, underrun, resume.
    for (int i = 0; i < 7; i++) begin
      for (int p = 0; p < vecs[i].n_push; p++)
        push_one(vecs[i].en, vecs[i].base + 8'(10 * p));
      run_bounds(vecs[i].en, vecs[i].n_bound);
      check($sformatf("v%0d_sample", i),       bus.sample,       vecs[i].exp_sample);
      check($sformatf("v%0d_level", i),        bus.level,        vecs[i].exp_level);
      check($sformatf("v%0d_underrun_cnt", i), bus.underrun_cnt, vecs[i].exp_cnt);
      check($sformatf("v%0d_underrun", i),     bus.underrun,     vecs[i].exp_und);
      if (i == 0) begin
        check("fs_count", fs_log.size(), 3);
        for (int k = 0; k < 3; k++)
          if (k < fs_log.size()) check($sformatf("fs_cycle%0d", k), fs_log[k], fs_exp[k]);
      end
    end

    // Full backpressure: producer always valid, one extra accept per boundary pop.
    nv = 8'd90;
    for (int f = 0; f < 3; f++) begin
      frame_hold(nv, acc_cnt, lvl_late, rdy_late);
      check($sformatf("bp%0d_accepts", f),     acc_cnt,    exp_acc[f]);
      check($sformatf("bp%0d_level_full", f),  lvl_late,   DEPTH);
      check($sformatf("bp%0d_ready_full", f),  rdy_late,   0);
      check($sformatf("bp%0d_sample", f),      bus.sample, exp_smp[f]);
      check($sformatf("bp%0d_level_after", f), bus.level,  7);
    end

    // Mute mid-run with five samples queued.
    run_bounds(1'b1, 2);
    repeat (100) tick(1'b1, 1'b0, 8'd0, acc);
    check("mute_pre_level",  bus.level,  5);
    check("mute_pre_sample", bus.sample, 91);
    tick(1'b0, 1'b0, 8'd0, acc);
    check("mute_level",    bus.level,    0);
    check("mute_in_ready", bus.in_ready, 0);
    check("mute_hold",     bus.sample,   91);
    run_bounds(1'b0, 1);
    check("mute_sample", bus.sample, MIDSCALE);

    // Restart, then an asynchronous reset pulse in the middle of a frame.
    for (int p = 0; p < 4; p++) push_one(1'b1, 8'(1 + 10 * p));
    run_bounds(1'b1, 1);
    check("restart_sample", bus.sample, 1);
    repeat (60) tick(1'b1, 1'b0, 8'd0, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Random traffic: bursty and sparse producers, occasional mute.
    for (int s = 0; s < 20; s++) begin
      logic en;
      int   rate;
      int   len;
      en   = ($urandom_range(0, 9) != 0);
      rate = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 12) : $urandom_range(0, 1000);
      len  = $urandom_range(50, 1200);
      for (int k = 0; k < len; k++)
        tick(en, ($urandom_range(0, 999) < rate), 8'($urandom_range(0, 255)), acc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
